csr_uart_rx: RTL and testbench

//  CSR-mapped UART receiver; counterpart of the CSR UART character-output path. Oversamples

---
 rtl/csr_uart_rx_if.sv | 12 +
 rtl/csr_uart_rx.sv | 162 ++++++++++++++++
 tb/tb_csr_uart_rx.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/csr_uart_rx_if.sv
// CSR bus bundle for csr_uart_rx: core side drives the request, the peripheral answers rdata/valid.
interface csr_uart_rx_if;
   logic        read;
   logic [2:0]  modify;
   logic [31:0] wdata;
   logic [11:0] addr;
   logic [31:0] rdata;
   logic        valid;

   modport master (output read, modify, wdata, addr, input rdata, valid);
   modport slave  (input read, modify, wdata, addr, output rdata, valid);
endinterface

// File: rtl/csr_uart_rx.sv
// CSR-mapped 8N1 UART receiver with a small byte FIFO; each read at BASE_ADDR pops one byte.
// Optional sticky overrun/framing flags in the read word when CSR_UART_RX_ERR_EN is defined.
module csr_uart_rx #(
   parameter logic [11:0] BASE_ADDR = 12'hBC0,
   parameter int          DIVISOR   = 868,
   parameter int          FIFO_LOG2 = 2
) (
   input  logic          clk,
   input  logic          rstn,
   csr_uart_rx_if.slave  bus,
   input  logic          rx
);
   localparam int DEPTH = 1 << FIFO_LOG2;
   localparam int CW    = $clog2(DIVISOR);
   localparam logic [CW-1:0] HALF = CW'(DIVISOR/2 - 1);
   localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [2:0]      bitc, bitc_n;
   logic [7:0]      shreg, shreg_n;
   logic            sync1, s_rx;
   logic            push_req, frame_err;
   logic [11:0]     q_addr;
   logic [FIFO_LOG2:0]   wptr, rptr;
   logic [7:0]      mem [DEPTH];
   logic            empty, full, rd_hit, pop, push;
   logic [7:0]      head;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         sync1 <= 1'b1;
         s_rx  <= 1'b1;
      end else begin
         sync1 <= rx;
         s_rx  <= sync1;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         cnt   <= '0;
         bitc  <= '0;
         shreg <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         bitc  <= bitc_n;
         shreg <= shreg_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt + 1'b1;
      bitc_n    = bitc;
      shreg_n   = shreg;
      push_req  = 1'b0;
      frame_err = 1'b0;
      case (state)
         IDLE: begin
            cnt_n = '0;
            if (!s_rx) state_n = START;
         end
         // Mid-start-bit check rejects short glitches before committing to a frame.
         START: if (cnt == HALF) begin
            cnt_n   = '0;
            bitc_n  = '0;
            state_n = s_rx ? IDLE : DATA;
         end
         DATA: if (cnt == LAST) begin
            cnt_n   = '0;
            shreg_n = {s_rx, shreg[7:1]};
            bitc_n  = bitc + 3'd1;
            if (bitc == 3'd7) state_n = STOP;
         end
         STOP: if (cnt == LAST) begin
            cnt_n = '0;
            if (s_rx) begin
               push_req = 1'b1;
               state_n  = IDLE;
            end else begin
               frame_err = 1'b1;
               state_n   = BREAK;
            end
         end
         BREAK: begin
            cnt_n = '0;
            if (s_rx) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign rd_hit = bus.read && (q_addr == BASE_ADDR);
   assign empty  = (wptr == rptr);
   assign full   = (wptr[FIFO_LOG2] != rptr[FIFO_LOG2]) &&
                   (wptr[FIFO_LOG2-1:0] == rptr[FIFO_LOG2-1:0]);
   assign pop    = rd_hit && !empty;
   // A pop on the same edge frees the slot, so a full FIFO can still accept.
   assign push   = push_req && (!full || pop);
   assign head   = mem[rptr[FIFO_LOG2-1:0]];

   always_ff @(posedge clk) begin
      if (push) mem[wptr[FIFO_LOG2-1:0]] <= shreg;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr   <= '0;
         rptr   <= '0;
         q_addr <= '0;
      end else begin
         q_addr <= bus.addr;
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

`ifdef CSR_UART_RX_ERR_EN
   logic ovr, ferr;
   logic unused;
   assign unused = ^{bus.modify, bus.wdata};

   // Set beats clear so an error on the popping edge is not lost.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ovr  <= 1'b0;
         ferr <= 1'b0;
      end else begin
         ovr  <= (push_req && full && !pop) || (ovr && !pop);
         ferr <= frame_err || (ferr && !pop);
      end
   end
`else
   logic unused;
   assign unused = ^{bus.modify, bus.wdata, frame_err};
`endif

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         bus.rdata <= '0;
         bus.valid <= 1'b0;
      end else if (rd_hit) begin
         bus.valid <= 1'b1;
         if (empty)
            bus.rdata <= 32'hFFFF_FFFF;
         else
`ifdef CSR_UART_RX_ERR_EN
            bus.rdata <= {22'b0, ovr, ferr, head};
`else
            bus.rdata <= {24'b0, head};
`endif
      end else begin
         bus.rdata <= '0;
         bus.valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_csr_uart_rx.sv
// Directed bench for csr_uart_rx: table of frame/read vectors plus hand-built corner sequences.
module tb_csr_uart_rx;
   localparam int DIV = 16;
   localparam logic [11:0] BASE = 12'hBC0;

   logic clk = 1'b0;
   logic rstn = 1'b0;
   logic rx = 1'b1;
   int   nvec = 0;
   int   nerr = 0;

   csr_uart_rx_if bus();

   csr_uart_rx #(.BASE_ADDR(BASE), .DIVISOR(DIV), .FIFO_LOG2(2)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus),
      .rx   (rx)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        send_en;
      logic [7:0]  b;
      logic [11:0] a;
      logic        exp_v;
      logic [31:0] exp_d;
   } vec_t;

   vec_t tbl [8];

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic stopb);
      rx = 1'b0;
      cyc(DIV);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         cyc(DIV);
      end
      rx = stopb;
      cyc(DIV);
   endtask

   task automatic rd(input string name, input logic [11:0] a, input logic exp_v, input logic [31:0] exp_d);
      logic        v, v2;
      logic [31:0] d;
      cyc(1);
      bus.addr = a;
      cyc(1);
      bus.read = 1'b1;
      cyc(1);
      bus.read = 1'b0;
      v = bus.valid;
      d = bus.rdata;
      cyc(1);
      v2 = bus.valid;
      chk({name, ".valid"}, {31'b0, v}, {31'b0, exp_v});
      chk({name, ".rdata"}, d, exp_d);
      chk({name, ".valid_drop"}, {31'b0, v2}, 32'h0);
   endtask

   initial begin
      tbl[0] = '{1'b0, 8'h00, BASE,     1'b1, 32'hFFFF_FFFF};
      tbl[1] = '{1'b0, 8'h00, 12'hBC1,  1'b0, 32'h0000_0000};
      tbl[2] = '{1'b1, 8'h55, BASE,     1'b1, 32'h0000_0055};
      tbl[3] = '{1'b0, 8'h00, BASE,     1'b1, 32'hFFFF_FFFF};
      tbl[4] = '{1'b1, 8'hAA, 12'hBC1,  1'b0, 32'h0000_0000};
      tbl[5] = '{1'b0, 8'h00, BASE,     1'b1, 32'h0000_00AA};
      tbl[6] = '{1'b1, 8'h00, BASE,     1'b1, 32'h0000_0000};
      tbl[7] = '{1'b1, 8'hFF, BASE,     1'b1, 32'h0000_00FF};

      bus.read   = 1'b0;
      bus.modify = 3'd0;
      bus.wdata  = 32'h0;
      bus.addr   = 12'h0;
      cyc(3);
      chk("reset.valid", {31'b0, bus.valid}, 32'h0);
      chk("reset.rdata", bus.rdata, 32'h0);
      rstn = 1'b1;
      cyc(5);

      for (int i = 0; i < 8; i++) begin
         if (tbl[i].send_en) send(tbl[i].b, 1'b1);
         cyc(4);
         rd($sformatf("tbl%0d", i), tbl[i].a, tbl[i].exp_v, tbl[i].exp_d);
      end

      // modify at the receive address without a read strobe
      bus.addr = BASE; bus.modify = 3'd3; bus.wdata = 32'h12;
      cyc(3);
      chk("modify.valid", {31'b0, bus.valid}, 32'h0);
      bus.modify = 3'd0; bus.wdata = 32'h0; bus.addr = 12'h0;

      // five back-to-back frames into a four-deep FIFO
      for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
      cyc(4);
`ifdef CSR_UART_RX_ERR_EN
      rd("ovr.r0", BASE, 1'b1, 32'h0000_0201);
`else
      rd("ovr.r0", BASE, 1'b1, 32'h0000_0001);
`endif
      rd("ovr.r1", BASE, 1'b1, 32'h0000_0002);
      rd("ovr.r2", BASE, 1'b1, 32'h0000_0003);
      rd("ovr.r3", BASE, 1'b1, 32'h0000_0004);
      rd("ovr.r4", BASE, 1'b1, 32'hFFFF_FFFF);

      // framing error followed by a held-low line
      send(8'hA3, 1'b0);
      cyc(40);
      rx = 1'b1;
      cyc(20);
      send(8'h3C, 1'b1);
      cyc(4);
`ifdef CSR_UART_RX_ERR_EN
      rd("ferr.r0", BASE, 1'b1, 32'h0000_013C);
`else
      rd("ferr.r0", BASE, 1'b1, 32'h0000_003C);
`endif
      rd("ferr.r1", BASE, 1'b1, 32'hFFFF_FFFF);

      // short low glitch in idle
      rx = 1'b0;
      cyc(5);
      rx = 1'b1;
      cyc(30);
      send(8'h7E, 1'b1);
      cyc(4);
      rd("glitch.r0", BASE, 1'b1, 32'h0000_007E);
      rd("glitch.r1", BASE, 1'b1, 32'hFFFF_FFFF);

      // reset during bit 4 with a byte already queued
      send(8'h11, 1'b1);
      rx = 1'b0;
      cyc(DIV);
      cyc(4 * DIV);
      rx = 1'b1;
      cyc(5);
      bus.addr = BASE;
      bus.read = 1'b1;
      rstn = 1'b0;
      cyc(3);
      chk("rst_mid.valid", {31'b0, bus.valid}, 32'h0);
      chk("rst_mid.rdata", bus.rdata, 32'h0);
      bus.read = 1'b0;
      rstn = 1'b1;
      cyc(40);
      send(8'h81, 1'b1);
      cyc(4);
      rd("rst.r0", BASE, 1'b1, 32'h0000_0081);
      rd("rst.r1", BASE, 1'b1, 32'hFFFF_FFFF);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
